// File: rtl/split_pkg.sv
// rtl/split_pkg.sv - shared memsim constants for port splitters
// Purpose: FSM state encoding and downstream port selector shared by
//          splitter-style blocks (split and future variants).
// Ports:   none (package).
package split_pkg;

  localparam int SPLIT_DEF_ADDR_WIDTH = 64;
  localparam int SPLIT_DEF_WORD_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACT0 = 2'd1,
    ST_ACT1 = 2'd2,
    ST_DONE = 2'd3
  } split_state_t;

  // Downstream port selector: which memory subsystem owns a request.
  typedef enum logic {
    PORT_0 = 1'b0,
    PORT_1 = 1'b1
  } split_port_t;

  // Map the "address at/above offset" compare result to a port.
  function automatic split_port_t split_port_of(input logic at_or_above);
    return at_or_above ? PORT_1 : PORT_0;
  endfunction

endpackage

// File: rtl/split.sv
// rtl/split.sv - memory-port demultiplexer, one master to two memory ports
// Purpose: routes each upstream request to port 0 (addr < OFFSET, unchanged)
//          or port 1 (addr >= OFFSET, rebased by -OFFSET), waits for the
//          selected port to complete, then pulses ready upstream for one cycle.
// Ports:   clk, rst (sync, active-high)
//          upstream:   addr, din, re, we in; dout, ready out
//          port 0/1:   addrN, doutN, reN, weN out; dinN, readyN in
//          all outputs are registered.
module split
  import split_pkg::*;
#(
  parameter int ADDR_WIDTH = SPLIT_DEF_ADDR_WIDTH,
  parameter int WORD_WIDTH = SPLIT_DEF_WORD_WIDTH,
  // One bit wider than an address so OFFSET >= 2^AW is expressible
  // (which routes everything to port 0).
  parameter logic [ADDR_WIDTH:0] OFFSET = (ADDR_WIDTH+1)'(128)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] din,
  output logic [WORD_WIDTH-1:0] dout,
  input  logic                  re,
  input  logic                  we,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [ADDR_WIDTH-1:0] addr1,
  output logic [WORD_WIDTH-1:0] dout0,
  output logic [WORD_WIDTH-1:0] dout1,
  input  logic [WORD_WIDTH-1:0] din0,
  input  logic [WORD_WIDTH-1:0] din1,
  output logic                  re0,
  output logic                  we0,
  output logic                  re1,
  output logic                  we1,
  input  logic                  ready0,
  input  logic                  ready1
);

  split_state_t          r_state;
  logic                  r_is_read;
  logic                  r_ready;
  logic [WORD_WIDTH-1:0] r_dout;
  logic [ADDR_WIDTH-1:0] r_addr0;
  logic [ADDR_WIDTH-1:0] r_addr1;
  logic [WORD_WIDTH-1:0] r_dout0;
  logic [WORD_WIDTH-1:0] r_dout1;
  logic                  r_re0;
  logic                  r_we0;
  logic                  r_re1;
  logic                  r_we1;

  split_port_t           w_port;
  logic [ADDR_WIDTH-1:0] w_addr_rebased;
  logic                  w_op_re;

  // Zero-extend the address so the compare stays unsigned and correct for
  // offsets beyond the address range.
  assign w_port         = split_port_of({1'b0, addr} >= OFFSET);
  assign w_addr_rebased = addr - OFFSET[ADDR_WIDTH-1:0];
  // Write wins when both strobes are presented; the read is dropped.
  assign w_op_re        = re & ~we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_is_read <= 1'b0;
      r_ready   <= 1'b0;
      r_dout    <= '0;
      r_addr0   <= '0;
      r_addr1   <= '0;
      r_dout0   <= '0;
      r_dout1   <= '0;
      r_re0     <= 1'b0;
      r_we0     <= 1'b0;
      r_re1     <= 1'b0;
      r_we1     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b0;
          if (re | we) begin
            r_is_read <= w_op_re;
            if (w_port == PORT_1) begin
              r_addr1 <= w_addr_rebased;
              r_dout1 <= din;
              r_re1   <= w_op_re;
              r_we1   <= we;
              r_state <= ST_ACT1;
            end else begin
              r_addr0 <= addr;
              r_dout0 <= din;
              r_re0   <= w_op_re;
              r_we0   <= we;
              r_state <= ST_ACT0;
            end
          end
        end
        // Only the selected port's ready is looked at; upstream strobes are
        // not re-examined until the transaction has fully retired.
        ST_ACT0: begin
          if (ready0) begin
            r_re0   <= 1'b0;
            r_we0   <= 1'b0;
            if (r_is_read) begin
              r_dout <= din0;
            end
            r_ready <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_ACT1: begin
          if (ready1) begin
            r_re1   <= 1'b0;
            r_we1   <= 1'b0;
            if (r_is_read) begin
              r_dout <= din1;
            end
            r_ready <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        // ready is high for the single cycle spent here; IDLE does not
        // sample the master until the following cycle, so a master that
        // drops its strobe on ready is never issued twice.
        ST_DONE: begin
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign dout  = r_dout;
  assign addr0 = r_addr0;
  assign addr1 = r_addr1;
  assign dout0 = r_dout0;
  assign dout1 = r_dout1;
  assign re0   = r_re0;
  assign we0   = r_we0;
  assign re1   = r_re1;
  assign we1   = r_we1;

endmodule

// File: tb/tb_split.sv
// tb/tb_split.sv - randomized self-checking bench for split
module tb_split;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] addr;
  logic [63:0] din;
  logic [63:0] dout;
  logic        re;
  logic        we;
  logic        ready;
  logic [63:0] addr0;
  logic [63:0] addr1;
  logic [63:0] dout0;
  logic [63:0] dout1;
  logic [63:0] din0;
  logic [63:0] din1;
  logic        re0;
  logic        we0;
  logic        re1;
  logic        we1;
  logic        ready0;
  logic        ready1;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_dout;

  always #5 clk = ~clk;

  split #(
    .ADDR_WIDTH(64),
    .WORD_WIDTH(64),
    .OFFSET    (65'd128)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .re    (re),
    .we    (we),
    .ready (ready),
    .addr0 (addr0),
    .addr1 (addr1),
    .dout0 (dout0),
    .dout1 (dout1),
    .din0  (din0),
    .din1  (din1),
    .re0   (re0),
    .we0   (we0),
    .re1   (re1),
    .we1   (we1),
    .ready0(ready0),
    .ready1(ready1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle_strobes(input string tag);
    check({tag, "_re0"}, {63'd0, re0}, 64'd0);
    check({tag, "_we0"}, {63'd0, we0}, 64'd0);
    check({tag, "_re1"}, {63'd0, re1}, 64'd0);
    check({tag, "_we1"}, {63'd0, we1}, 64'd0);
  endtask

  // One upstream transaction, driven and checked on falling edges.
  // Reference: port 1 iff a >= 128, port-1 address is a-128, write beats read,
  // strobe one cycle after request, ready one cycle after readyN.
  task automatic txn(input logic [63:0] a, input bit r, input bit w,
                     input logic [63:0] d, input logic [63:0] rd, input int lat,
                     input bit stray, input bit drop_mid, input bit hold);
    bit          sel;
    bit          m_re;
    bit          m_we;
    logic [63:0] m_addr;
    sel    = (a >= 64'd128);
    m_we   = w;
    m_re   = r && !w;
    m_addr = sel ? a - 64'd128 : a;
    addr = a; din = d; re = r; we = w;
    @(negedge clk);
    for (int c = 0; c <= lat; c++) begin
      check("re0",   {63'd0, re0}, {63'd0, !sel && m_re});
      check("we0",   {63'd0, we0}, {63'd0, !sel && m_we});
      check("re1",   {63'd0, re1}, {63'd0, sel && m_re});
      check("we1",   {63'd0, we1}, {63'd0, sel && m_we});
      check("ready_wait", {63'd0, ready}, 64'd0);
      if (c == 0) begin
        if (sel) begin
          check("addr1", addr1, m_addr);
          check("dout1", dout1, d);
        end else begin
          check("addr0", addr0, m_addr);
          check("dout0", dout0, d);
        end
        if (drop_mid) begin
          re = 1'b0; we = 1'b0;
        end
      end
      if (c == lat) begin
        if (sel) begin ready1 = 1'b1; din1 = rd; end
        else     begin ready0 = 1'b1; din0 = rd; end
      end else if (stray) begin
        if (sel) begin ready0 = 1'b1; din0 = {$urandom, $urandom}; end
        else     begin ready1 = 1'b1; din1 = {$urandom, $urandom}; end
      end
      @(negedge clk);
      ready0 = 1'b0; ready1 = 1'b0;
    end
    if (m_re) exp_dout = rd;
    check("ready_pulse", {63'd0, ready}, 64'd1);
    check("dout", dout, exp_dout);
    check_idle_strobes("done");
    if (!hold) begin
      re = 1'b0; we = 1'b0;
    end
    @(negedge clk);
    check("ready_drop", {63'd0, ready}, 64'd0);
    check_idle_strobes("after");
  endtask

  initial begin
    rst = 1'b1; addr = '0; din = '0; re = 1'b0; we = 1'b0;
    din0 = '0; din1 = '0; ready0 = 1'b0; ready1 = 1'b0;
    exp_dout = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_dout", dout, 64'd0);
    check("rst_addr0", addr0, 64'd0);
    check("rst_addr1", addr1, 64'd0);
    check("rst_dout0", dout0, 64'd0);
    check("rst_dout1", dout1, 64'd0);
    check_idle_strobes("rst");
    rst = 1'b0;
    @(negedge clk);

    // Basic read on port 0, immediate response.
    txn(64'h10, 1, 0, 64'h0, 64'hAA, 0, 0, 0, 0);
    // Write on port 1 with a slow responder.
    txn(64'h90, 0, 1, 64'h55, 64'h1234, 4, 0, 0, 0);
    // Boundary addresses.
    txn(64'h7F, 1, 0, 64'h0, 64'h77, 1, 0, 0, 0);
    txn(64'h80, 1, 0, 64'h0, 64'h88, 1, 0, 0, 0);
    // Back-to-back with re held across ready.
    txn(64'h20, 1, 0, 64'h0, 64'hB1, 1, 0, 0, 1);
    txn(64'hA0, 1, 0, 64'h0, 64'hB2, 0, 0, 0, 0);
    // Stray ready1 during ACT0, and re&we together.
    txn(64'h30, 1, 0, 64'h0, 64'hC3, 3, 1, 0, 0);
    txn(64'h40, 1, 1, 64'hD4, 64'hDEAD, 2, 1, 0, 0);
    txn(64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 64'hE5, 64'hBEEF, 1, 0, 1, 0);

    // Reset while port 1 is active.
    addr = 64'h100; din = 64'h9; re = 1'b1; we = 1'b0;
    @(negedge clk);
    check("pre_rst_re1", {63'd0, re1}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; re = 1'b0;
    exp_dout = '0;
    check("midrst_ready", {63'd0, ready}, 64'd0);
    check("midrst_addr1", addr1, 64'd0);
    check("midrst_dout", dout, 64'd0);
    check_idle_strobes("midrst");
    ready1 = 1'b1; din1 = 64'hF00D;
    repeat (3) begin
      @(negedge clk);
      check("late_ready1", {63'd0, ready}, 64'd0);
      check_idle_strobes("late");
    end
    ready1 = 1'b0;
    @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      logic [63:0] a;
      int          kind;
      int          op;
      kind = $urandom_range(0, 2);
      case (kind)
        0:       a = 64'($urandom_range(0, 255));
        1:       a = 64'($urandom_range(126, 129));
        default: a = {$urandom, $urandom};
      endcase
      op = $urandom_range(0, 3);
      txn(a, op != 1, op == 1 || op == 2, {$urandom, $urandom}, {$urandom, $urandom},
          $urandom_range(0, 4), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end
    re = 1'b0; we = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
